// File: rtl/vector_addsub_pipe.sv
// Element-wise FP16 vector add/subtract. Each lane has a fixed-latency fp16add core.
// A valid shift register follows the cores into a credit-limited output FIFO.

module fp16add #(
    parameter int LAT = 10
) (
    input  logic        clk,
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic [15:0] q
);
    // Exact add: align both significands in a 42-bit field so that no bit is lost.
    // Then normalise and round once, to nearest even.
    function automatic logic [15:0] fp16_add(input logic [15:0] fa, input logic [15:0] fb);
        logic [15:0] x, y;
        logic [10:0] mx, my, mant;
        logic [41:0] ax, ay, sum, mask;
        logic [4:0]  base;
        logic [16:0] res;
        logic        a_nan, b_nan, a_inf, b_inf, g, s, rnd, eff_sub;
        int          ex, ey, d, lead, e_res, sh;
        a_nan = (fa[14:10] == 5'h1f) && (fa[9:0] != 10'd0);
        b_nan = (fb[14:10] == 5'h1f) && (fb[9:0] != 10'd0);
        a_inf = (fa[14:10] == 5'h1f) && (fa[9:0] == 10'd0);
        b_inf = (fb[14:10] == 5'h1f) && (fb[9:0] == 10'd0);
        if (a_nan || b_nan || (a_inf && b_inf && (fa[15] != fb[15])))
            return 16'h7e00;
        if (a_inf)
            return fa;
        if (b_inf)
            return fb;
        if (fb[14:0] > fa[14:0]) begin
            x = fb;
            y = fa;
        end else begin
            x = fa;
            y = fb;
        end
        ex = (x[14:10] == 5'd0) ? 1 : int'(x[14:10]);
        ey = (y[14:10] == 5'd0) ? 1 : int'(y[14:10]);
        mx = {(x[14:10] != 5'd0), x[9:0]};
        my = {(y[14:10] != 5'd0), y[9:0]};
        d  = ex - ey;
        eff_sub = x[15] ^ y[15];
        ax  = {1'b0, mx, 30'd0};
        ay  = {1'b0, my, 30'd0} >> d;
        sum = eff_sub ? (ax - ay) : (ax + ay);
        if (sum == 42'd0)
            return {x[15] & y[15], 15'd0};
        lead = 0;
        for (int i = 0; i < 42; i++)
            if (sum[i])
                lead = i;
        e_res = ex + lead - 40;
        sh    = ((e_res >= 1) ? e_res : 1) + 30 - ex;
        base  = (e_res >= 1) ? 5'(e_res - 1) : 5'd0;
        mant  = 11'(sum >> sh);
        mask  = (42'd1 << (sh - 1)) - 42'd1;
        g     = |(sum & (42'd1 << (sh - 1)));
        s     = |(sum & mask);
        rnd   = g & (s | mant[0]);
        res   = {2'b00, base, 10'd0} + {6'd0, mant} + {16'd0, rnd};
        if (res >= 17'h07c00)
            return {x[15], 15'h7c00};
        return {x[15], res[14:0]};
    endfunction

    logic [15:0] pipe [LAT];

    always_ff @(posedge clk) begin
        pipe[0] <= fp16_add(a, b);
        for (int k = 1; k < LAT; k++)
            pipe[k] <= pipe[k-1];
    end

    assign q = pipe[LAT-1];
endmodule

module vector_addsub_pipe #(
    parameter int LANES = 3,
    parameter int LAT   = 10,
    parameter int DEPTH = 12
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic                op,
    input  logic [16*LANES-1:0] vec_a,
    input  logic [16*LANES-1:0] vec_b,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [16*LANES-1:0] vec_q,
    output logic                busy
);
    localparam int W  = 16 * LANES;
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    // Handshake: a transfer happens on a rising edge where valid and ready are both high.
    // The source holds its data while ready is low.
    logic          acc, push, pop;
    logic [LAT-1:0] vld_pipe;
    logic [W-1:0]  core_q;
    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count, occ;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        logic [15:0] b_eff;
        assign b_eff = op ? {~vec_b[16*i+15], vec_b[16*i+14 -: 15]} : vec_b[16*i +: 16];
        fp16add #(.LAT(LAT)) u_core (
            .clk (clk),
            .a   (vec_a[16*i +: 16]),
            .b   (b_eff),
            .q   (core_q[16*i +: 16])
        );
    end

    assign in_ready  = rst_n & (occ < CW'(DEPTH));
    assign acc       = in_valid & in_ready;
    assign push      = vld_pipe[LAT-1];
    assign out_valid = (count != '0);
    assign pop       = out_valid & out_ready;
    assign vec_q     = mem[rd_ptr];
    assign busy      = (occ != '0);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_pipe <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            occ      <= '0;
        end else begin
            vld_pipe[0] <= acc;
            for (int k = 1; k < LAT; k++)
                vld_pipe[k] <= vld_pipe[k-1];
            if (push)
                wr_ptr <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            case ({acc, pop})
                2'b10:   occ <= occ + 1'b1;
                2'b01:   occ <= occ - 1'b1;
                default: occ <= occ;
            endcase
        end
    end

    // Storage is not reset; out_valid masks stale entries.
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= core_q;
    end
endmodule
